cnn_top: RTL and testbench
==========================

// Module: cnn_top
// PURPOSE
//  Single-core CNN inference engine of the multi-core ML accelerator. Takes an 8x8 image of
//  32-bit signed pixels and runs conv3x3 (fixed kernel) -> ReLU -> 2x2 maxpool -> fully-connected sum.
//  Produces one 32-bit prediction score plus a done flag.
//  Top of the cnn_core; a future dispatcher drives enable/input_img and collects value/done.
// PARAMETERS
//  IMG_SIZE   64  pixel count; fixed 8x8 (IMG_DIM=8). Other values unsupported.
//  OUT_WIDTH  32  width of value and of all internal datapath words.
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  enable     in   1      start request; sampled in IDLE and DONE only
//  input_img  in   32x64  unpacked array [0:63]; pixel (r,c) = input_img[r*8+c]; signed two's complement
//  value      out  32     prediction score; registered; signed
//  done       out  1      registered; high while the result in value is valid
// BEHAVIOUR
//  - Reset: state=IDLE, value=0, done=0, all internal buffers and counters=0. Reset mid-run aborts to IDLE.
//  - FSM: IDLE -> CONV -> POOL -> FC -> DONE.
//    IDLE->CONV when enable=1; same edge copies all 64 pixels into an internal image buffer.
//    input_img is ignored at every other edge.
//  - CONV: 36 cycles, one output per cycle in raster order (r,c in 0..5).
//    f(r,c) = ReLU(sum_{i,j in 0..2} K[i][j]*img(r+i,c+j)).
//    K = {1,1,1; 1,2,1; 1,1,1}.
//  - POOL: 9 cycles in raster order. p(a,b) = signed max of f(2a..2a+1, 2b..2b+1).
//  - FC: 9 cycles. acc += W[n]*p(n); W[n]=1 for all n; bias 0; acc cleared on entry to CONV.
//  - Timing: run-start edge = edge 0. value and done update on edge 55. Fixed latency, data-independent.
//  - Arithmetic: signed 32-bit. Products and sums keep the low 32 bits (wrap, no saturation).
//    ReLU maps negative to 0.
//  - DONE: done=1 and value is held while enable=1.
//    On enable=0, go to IDLE next edge: done->0, value keeps last result.
//    Re-raising enable starts a new run.
//  - enable changes during CONV/POOL/FC are ignored; the run always completes.
//  - Start in the cycle after leaving DONE requires enable to have gone low (no back-to-back without handshake).
// STRUCTURE
//  - Package cnn_pkg: IMG_DIM=8, KDIM=3, CONV_DIM=6, POOL_DIM=3, CONV_CYC=36, POOL_CYC=9, FC_CYC=9.
//    Also KERNEL[0:8], FC_W[0:8], and the state enum {IDLE,CONV,POOL,FC,DONE}.
//  - Sub-module cnn_conv3x3: combinational 9-tap MAC + ReLU over a 3x3 window, 32-bit wrap.
//    cnn_top owns the FSM, counters, image/feature/pool buffers, maxpool and FC accumulator.
// TESTING
//  1 Assert rst 2 cycles with enable=1 -> value=0, done=0, no run starts while rst=1.
//  2 All pixels=1, enable pulse held -> done rises exactly 55 edges after the start edge, value=90.
//  3 All pixels=0 -> value=0, done=1.
//  4 input_img[27]=100, others 0 -> value=500 (pooled 100,100,100,200 + zeros).
//  5 All pixels=32'hFFFFFFFF (-1) -> conv=-10, ReLU 0, value=0.
//  6 Handshake: hold enable -> done stays 1; drop enable -> done=0 next edge, value kept;
//    change input_img mid-run -> result unchanged; rst mid-CONV -> IDLE, value=0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and helpers for the single-core CNN engine.
// Fixed 8x8 image, 3x3 kernel, 2x2 pooling, 9-input fully-connected sum.
package cnn_pkg;

  localparam int IMG_DIM  = 8;
  localparam int KDIM     = 3;
  localparam int CONV_DIM = 6;
  localparam int POOL_DIM = 3;
  localparam int CONV_CYC = 36;
  localparam int POOL_CYC = 9;
  localparam int FC_CYC   = 9;
  localparam int DW       = 32;

  localparam logic signed [DW-1:0] KERNEL [0:8] = '{
    32'sd1, 32'sd1, 32'sd1,
    32'sd1, 32'sd2, 32'sd1,
    32'sd1, 32'sd1, 32'sd1
  };

  localparam logic signed [DW-1:0] FC_W [0:8] = '{
    32'sd1, 32'sd1, 32'sd1,
    32'sd1, 32'sd1, 32'sd1,
    32'sd1, 32'sd1, 32'sd1
  };

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONV = 3'd1,
    POOL = 3'd2,
    FC   = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic logic [5:0] pix_idx(input logic [2:0] r, input logic [2:0] c);
    return 6'(int'(r) * IMG_DIM + int'(c));
  endfunction

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cnn_conv3x3.sv
// Combinational 9-tap multiply-accumulate with ReLU; zero latency, no flow control.
// Sums wrap at 32 bits; negative results clamp to zero.
module cnn_conv3x3
  import cnn_pkg::*;
(
  input  logic signed [DW-1:0] i_win [0:8],
  output logic signed [DW-1:0] o_relu
);

  logic signed [DW-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < KDIM * KDIM; k++) begin
      w_sum = w_sum + i_win[k] * KERNEL[k];
    end
    o_relu = w_sum[DW-1] ? '0 : w_sum;
  end

endmodule

// File: rtl/cnn_top.sv
// CNN core: conv3x3 -> ReLU -> 2x2 maxpool -> FC sum; result 55 edges after the start edge.
// No backpressure: enable is a start request honoured only in IDLE/DONE, a run always completes.
module cnn_top
  import cnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic signed [DW-1:0] input_img [0:63],
  output logic signed [DW-1:0] value,
  output logic                 done
);

  state_t               r_state;
  logic signed [DW-1:0] r_img  [0:63];
  logic signed [DW-1:0] r_feat [0:35];
  logic signed [DW-1:0] r_pool [0:8];
  logic signed [DW-1:0] r_acc;
  logic [5:0]           r_cnt;
  logic [2:0]           r_row;
  logic [2:0]           r_col;

  logic signed [DW-1:0] w_win [0:8];
  logic signed [DW-1:0] w_relu;
  logic [5:0]           w_pbase;
  logic signed [DW-1:0] w_pmax;

  // Window origin is (r_row, r_col); rows/cols never exceed 7 while in CONV.
  for (genvar gi = 0; gi < KDIM; gi++) begin : g_row
    for (genvar gj = 0; gj < KDIM; gj++) begin : g_col
      assign w_win[gi*KDIM+gj] = r_img[pix_idx(r_row + 3'(gi), r_col + 3'(gj))];
    end
  end

  cnn_conv3x3 u_conv (
    .i_win  (w_win),
    .o_relu (w_relu)
  );

  always_comb begin
    w_pbase = 6'(r_row) * 6'(2*CONV_DIM) + 6'(r_col) * 6'd2;
    w_pmax  = smax(smax(r_feat[w_pbase],             r_feat[w_pbase + 6'd1]),
                   smax(r_feat[w_pbase + 6'(CONV_DIM)], r_feat[w_pbase + 6'(CONV_DIM+1)]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      value   <= '0;
      done    <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      for (int k = 0; k < 64; k++) r_img[k] <= '0;
      for (int k = 0; k < 36; k++) r_feat[k] <= '0;
      for (int k = 0; k < 9; k++)  r_pool[k] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_img   <= input_img;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_feat[r_cnt] <= w_relu;
          if (r_cnt == 6'(CONV_CYC-1)) begin
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= POOL;
          end else begin
            r_cnt <= r_cnt + 6'd1;
            if (r_col == 3'(CONV_DIM-1)) begin
              r_col <= '0;
              r_row <= r_row + 3'd1;
            end else begin
              r_col <= r_col + 3'd1;
            end
          end
        end
        POOL: begin
          r_pool[r_cnt[3:0]] <= w_pmax;
          if (r_cnt == 6'(POOL_CYC-1)) begin
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= FC;
          end else begin
            r_cnt <= r_cnt + 6'd1;
            if (r_col == 3'(POOL_DIM-1)) begin
              r_col <= '0;
              r_row <= r_row + 3'd1;
            end else begin
              r_col <= r_col + 3'd1;
            end
          end
        end
        FC: begin
          // Nine accumulate edges, then one edge to publish the sum.
          if (r_cnt == 6'(FC_CYC)) begin
            value   <= r_acc;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_acc <= r_acc + FC_W[r_cnt[3:0]] * r_pool[r_cnt[3:0]];
            r_cnt <= r_cnt + 6'd1;
          end
        end
        DONE: begin
          if (!enable) begin
            done    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_top.sv
// Scoreboard bench for cnn_top: expected scores queued at run start, compared when done rises.
module tb_cnn_top;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [31:0] img [0:63];
  logic signed [31:0] value;
  logic               done;

  int                 n_chk = 0;
  int                 n_err = 0;
  logic signed [31:0] exp_q [$];

  cnn_top dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .input_img (img),
    .value     (value),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
               tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // Reference score computed straight from the pixel definition.
  function automatic logic signed [31:0] model();
    logic signed [31:0] f [0:35];
    logic signed [31:0] s, m, acc;
    int kw;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            kw = (i == 1 && j == 1) ? 2 : 1;
            s = s + kw * img[(r+i)*8 + c + j];
          end
        end
        f[r*6+c] = (s < 0) ? 32'sd0 : s;
      end
    end
    acc = 0;
    for (int a = 0; a < 3; a++) begin
      for (int b = 0; b < 3; b++) begin
        m = f[(2*a)*6 + 2*b];
        if (f[(2*a)*6 + 2*b + 1] > m)   m = f[(2*a)*6 + 2*b + 1];
        if (f[(2*a+1)*6 + 2*b] > m)     m = f[(2*a+1)*6 + 2*b];
        if (f[(2*a+1)*6 + 2*b + 1] > m) m = f[(2*a+1)*6 + 2*b + 1];
        acc = acc + m;
      end
    end
    return acc;
  endfunction

  task automatic fill(input logic signed [31:0] v);
    for (int k = 0; k < 64; k++) img[k] = v;
  endtask

  // Raise enable; returns just after the start edge.
  task automatic start_run();
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Waits for done, counting edges from the start edge (already_seen edges consumed).
  task automatic wait_done(input string tag, input int already_seen);
    int lat;
    lat = 0;
    for (int k = already_seen + 1; k <= 120; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    check_val({tag, "_latency"}, lat, 55);
    check_val({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) check_val({tag, "_value"}, value, exp_q.pop_front());
  endtask

  task automatic hold_and_drop(input string tag, input logic signed [31:0] exp);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_val({tag, "_hold_done"}, done, 1);
      check_val({tag, "_hold_value"}, value, exp);
    end
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_val({tag, "_drop_done"}, done, 0);
    check_val({tag, "_drop_value"}, value, exp);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    fill(32'sd1);

    // Reset dominates enable.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_value", value, 0);
    check_val("rst_done", done, 0);
    @(negedge clk);
    enable = 1'b0;
    rst    = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check_val("rst_no_run", done, 0);

    fill(32'sd1);
    exp_q.push_back(32'sd90);
    start_run();
    wait_done("ones", 0);
    hold_and_drop("ones", 32'sd90);

    fill(32'sd0);
    exp_q.push_back(32'sd0);
    start_run();
    wait_done("zeros", 0);
    hold_and_drop("zeros", 32'sd0);

    fill(32'sd0);
    img[27] = 32'sd100;
    exp_q.push_back(32'sd500);
    start_run();
    wait_done("single", 0);
    hold_and_drop("single", 32'sd500);

    fill(-32'sd1);
    exp_q.push_back(32'sd0);
    start_run();
    wait_done("neg", 0);
    hold_and_drop("neg", 32'sd0);

    // Input and enable changes after the start edge must not affect the run.
    fill(32'sd1);
    exp_q.push_back(32'sd90);
    start_run();
    repeat (10) @(posedge clk);
    #1;
    fill(32'sd0);
    img[27] = 32'sd100;
    enable  = 1'b0;
    wait_done("midrun", 10);
    @(posedge clk);
    #1;
    check_val("midrun_idle_done", done, 0);
    check_val("midrun_idle_value", value, 32'sd90);

    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 64; k++) img[k] = int'($urandom_range(0, 2000)) - 1000;
      exp_q.push_back(model());
      start_run();
      wait_done("random", 0);
      @(negedge clk);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check_val("random_drop_done", done, 0);
    end

    // Reset mid-CONV aborts and clears the previous result.
    fill(32'sd1);
    start_run();
    repeat (5) @(posedge clk);
    #1;
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst_done", done, 0);
    check_val("midrst_value", value, 0);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check_val("midrst_no_done", done, 0);
    check_val("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
